// File: rtl/address_range_sequencer_pkg.sv
// Shared types for the address range sequencer.
package address_range_sequencer_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } seq_state_t;

endpackage

// File: rtl/address_range_sequencer_address_index_step.sv
// Next (index, address) pair inside a non-aligned range, or the first pair of a burst
// when i_load is set.
module address_index_step #(
  parameter int ADDR_COUNT = 1,
  parameter int ADDR_BASE  = 0,
  parameter int ADDR_WIDTH = 1
) (
  input  logic                  i_load,
  input  logic [ADDR_WIDTH-1:0] i_index,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic [ADDR_WIDTH-1:0] o_index,
  output logic [ADDR_WIDTH-1:0] o_address
);

  localparam logic [ADDR_WIDTH-1:0] BASE_LSB   = ADDR_WIDTH'(ADDR_BASE);
  localparam logic [ADDR_WIDTH-1:0] LAST_INDEX = ADDR_WIDTH'(ADDR_COUNT - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE        = ADDR_WIDTH'(1);

  // The base add only feeds the first-beat load; stepping is a plain increment.
  always_comb begin
    o_index   = '0;
    o_address = '0;
    if (i_load) begin
      o_index   = i_index;
      o_address = BASE_LSB + i_index;
    end else if (i_index == LAST_INDEX) begin
      o_index   = '0;
      o_address = BASE_LSB;
    end else begin
      o_index   = i_index + ONE;
      o_address = i_address + ONE;
    end
  end

endmodule

// File: rtl/address_range_sequencer.sv
// Streams raw addresses for a burst over a non-aligned range with index wrap.
// ST_IDLE | accepts or rejects a command; ST_RUN | emits one beat per out_ready.
module address_range_sequencer
  import address_range_sequencer_pkg::*;
#(
  parameter int ADDR_COUNT = 1,
  parameter int ADDR_BASE  = 0,
  parameter int ADDR_WIDTH = 1
) (
  input  logic                  i_clock,
  input  logic                  i_clear,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic [ADDR_WIDTH-1:0] i_cmd_index,
  input  logic [ADDR_WIDTH:0]   i_cmd_length,
  output logic                  o_cmd_error,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic [ADDR_WIDTH-1:0] o_out_address,
  output logic [ADDR_WIDTH-1:0] o_out_index,
  output logic                  o_out_last
);

  localparam logic [ADDR_WIDTH:0] COUNT_LEN = (ADDR_WIDTH+1)'(ADDR_COUNT);
  localparam logic [ADDR_WIDTH:0] ONE_LEN   = (ADDR_WIDTH+1)'(1);

  seq_state_t              r_state;
  seq_state_t              w_state_next;
  logic [ADDR_WIDTH-1:0]   r_index;
  logic [ADDR_WIDTH-1:0]   r_address;
  logic [ADDR_WIDTH:0]     r_remaining;
  logic                    r_error;

  logic                    w_idle;
  logic                    w_cmd_ok;
  logic                    w_accept;
  logic                    w_beat;
  logic                    w_last;
  logic [ADDR_WIDTH-1:0]   w_step_in_index;
  logic [ADDR_WIDTH-1:0]   w_step_index;
  logic [ADDR_WIDTH-1:0]   w_step_address;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_cmd_ok = (i_cmd_length != '0) && (i_cmd_length <= COUNT_LEN) &&
                    ({1'b0, i_cmd_index} < COUNT_LEN);
  assign w_accept = w_idle && i_cmd_valid && w_cmd_ok;
  assign w_last   = (r_remaining == ONE_LEN);
  assign w_beat   = (r_state == ST_RUN) && i_out_ready;

  assign w_step_in_index = w_idle ? i_cmd_index : r_index;

  address_index_step #(
    .ADDR_COUNT (ADDR_COUNT),
    .ADDR_BASE  (ADDR_BASE),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_step (
    .i_load    (w_idle),
    .i_index   (w_step_in_index),
    .i_address (r_address),
    .o_index   (w_step_index),
    .o_address (w_step_address)
  );

  always_ff @(posedge i_clock) begin
    if (i_clear) r_state <= ST_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (i_cmd_valid && w_cmd_ok) w_state_next = ST_RUN;
      ST_RUN:  if (i_out_ready && w_last)   w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_cmd_ready = (r_state == ST_IDLE);
    o_out_valid = (r_state == ST_RUN);
    o_out_last  = (r_state == ST_RUN) && w_last;
  end

  always_ff @(posedge i_clock) begin
    if (i_clear) begin
      r_index     <= '0;
      r_address   <= '0;
      r_remaining <= '0;
      r_error     <= 1'b0;
    end else begin
      r_error <= w_idle && i_cmd_valid && !w_cmd_ok;
      if (w_accept) begin
        r_index     <= w_step_index;
        r_address   <= w_step_address;
        r_remaining <= i_cmd_length;
      end else if (w_beat) begin
        r_index     <= w_step_index;
        r_address   <= w_step_address;
        r_remaining <= r_remaining - ONE_LEN;
      end
    end
  end

  assign o_cmd_error   = r_error;
  assign o_out_address = r_address;
  assign o_out_index   = r_index;

endmodule

// File: tb/tb_address_range_sequencer.sv
// Directed and randomised checks of the sequencer with a 5-entry range at base 6 (3 bits)
// and a single-entry range at base 3 (1 bit).
module tb_address_range_sequencer;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_clear, a_cmd_valid, a_cmd_ready, a_cmd_error;
  logic       a_out_valid, a_out_ready, a_out_last;
  logic [2:0] a_cmd_index, a_out_address, a_out_index;
  logic [3:0] a_cmd_length;

  logic       b_clear, b_cmd_valid, b_cmd_ready, b_cmd_error;
  logic       b_out_valid, b_out_ready, b_out_last;
  logic [0:0] b_cmd_index, b_out_address, b_out_index;
  logic [1:0] b_cmd_length;

  int n_pass  = 0;
  int n_total = 0;

  address_range_sequencer #(.ADDR_COUNT(5), .ADDR_BASE(6), .ADDR_WIDTH(3)) dut_a (
    .i_clock(clk), .i_clear(a_clear), .i_cmd_valid(a_cmd_valid), .o_cmd_ready(a_cmd_ready),
    .i_cmd_index(a_cmd_index), .i_cmd_length(a_cmd_length), .o_cmd_error(a_cmd_error),
    .o_out_valid(a_out_valid), .i_out_ready(a_out_ready), .o_out_address(a_out_address),
    .o_out_index(a_out_index), .o_out_last(a_out_last));

  address_range_sequencer #(.ADDR_COUNT(1), .ADDR_BASE(3), .ADDR_WIDTH(1)) dut_b (
    .i_clock(clk), .i_clear(b_clear), .i_cmd_valid(b_cmd_valid), .o_cmd_ready(b_cmd_ready),
    .i_cmd_index(b_cmd_index), .i_cmd_length(b_cmd_length), .o_cmd_error(b_cmd_error),
    .o_out_valid(b_out_valid), .i_out_ready(b_out_ready), .o_out_address(b_out_address),
    .o_out_index(b_out_index), .o_out_last(b_out_last));

  // Address range translator: raw address back to consecutive index.
  function automatic int xlate_a(input logic [2:0] addr);
    logic [2:0] d;
    d = addr - 3'd6;
    return int'(d);
  endfunction

  function automatic int xlate_b(input logic [0:0] addr);
    logic [0:0] d;
    d = addr - 1'b1;
    return int'(d);
  endfunction

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    a_clear = 1'b1; b_clear = 1'b1;
    a_cmd_valid = 1'b0; a_cmd_index = '0; a_cmd_length = '0; a_out_ready = 1'b1;
    b_cmd_valid = 1'b0; b_cmd_index = '0; b_cmd_length = '0; b_out_ready = 1'b1;
    cyc; cyc;
    @(negedge clk);
    n_total++; if (a_cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready got %b want 1", a_cmd_ready); else n_pass++;
    n_total++; if (a_out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", a_out_valid); else n_pass++;
    n_total++; if (a_cmd_error !== 1'b0) $display("FAIL reset_cmd_error got %b want 0", a_cmd_error); else n_pass++;
    n_total++; if (a_out_address !== 3'd0) $display("FAIL reset_address got %0d want 0", a_out_address); else n_pass++;
    n_total++; if (a_out_index !== 3'd0) $display("FAIL reset_index got %0d want 0", a_out_index); else n_pass++;
    n_total++; if (a_out_last !== 1'b0) $display("FAIL reset_last got %b want 0", a_out_last); else n_pass++;
    n_total++; if (b_cmd_ready !== 1'b1 || b_out_valid !== 1'b0) $display("FAIL reset_b ready=%b valid=%b want 1,0", b_cmd_ready, b_out_valid); else n_pass++;
    cyc;
    a_clear = 1'b0; b_clear = 1'b0;
    cyc;
  endtask

  task automatic test_full_burst;
    int ea[5] = '{6, 7, 0, 1, 2};
    a_out_ready = 1'b1;
    a_cmd_valid = 1'b1; a_cmd_index = 3'd0; a_cmd_length = 4'd5;
    @(negedge clk);
    n_total++; if (a_cmd_ready !== 1'b1) $display("FAIL full_idle_ready got %b want 1", a_cmd_ready); else n_pass++;
    cyc;
    a_cmd_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_total++; if (a_out_valid !== 1'b1) $display("FAIL full_valid beat %0d got %b want 1", k, a_out_valid); else n_pass++;
      n_total++; if (a_out_address !== 3'(ea[k])) $display("FAIL full_addr beat %0d got %0d want %0d", k, a_out_address, ea[k]); else n_pass++;
      n_total++; if (a_out_index !== 3'(k)) $display("FAIL full_index beat %0d got %0d want %0d", k, a_out_index, k); else n_pass++;
      n_total++; if (a_out_last !== (k == 4)) $display("FAIL full_last beat %0d got %b want %b", k, a_out_last, k == 4); else n_pass++;
      cyc;
    end
    @(negedge clk);
    n_total++; if (a_out_valid !== 1'b0 || a_cmd_ready !== 1'b1) $display("FAIL full_end valid=%b ready=%b want 0,1", a_out_valid, a_cmd_ready); else n_pass++;
    cyc;
  endtask

  task automatic test_wrap_burst;
    int ei[4] = '{3, 4, 0, 1};
    int ea[4] = '{1, 2, 6, 7};
    a_out_ready = 1'b1;
    a_cmd_valid = 1'b1; a_cmd_index = 3'd3; a_cmd_length = 4'd4;
    cyc;
    // Keep offering a bad command while running: it must be ignored without error.
    a_cmd_length = 4'd0;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) a_cmd_valid = 1'b0;
      @(negedge clk);
      n_total++; if (a_out_address !== 3'(ea[k])) $display("FAIL wrap_addr beat %0d got %0d want %0d", k, a_out_address, ea[k]); else n_pass++;
      n_total++; if (a_out_index !== 3'(ei[k])) $display("FAIL wrap_index beat %0d got %0d want %0d", k, a_out_index, ei[k]); else n_pass++;
      n_total++; if (a_out_last !== (k == 3)) $display("FAIL wrap_last beat %0d got %b want %b", k, a_out_last, k == 3); else n_pass++;
      n_total++; if (a_cmd_ready !== 1'b0 || a_cmd_error !== 1'b0) $display("FAIL wrap_run_cmd beat %0d ready=%b err=%b want 0,0", k, a_cmd_ready, a_cmd_error); else n_pass++;
      cyc;
    end
    @(negedge clk);
    n_total++; if (a_out_valid !== 1'b0 || a_cmd_ready !== 1'b1) $display("FAIL wrap_end valid=%b ready=%b want 0,1", a_out_valid, a_cmd_ready); else n_pass++;
    cyc;
  endtask

  task automatic test_backpressure;
    logic rdy[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    int   ea[8]  = '{6, 7, 7, 7, 7, 0, 1, 2};
    int   ei[8]  = '{0, 1, 1, 1, 1, 2, 3, 4};
    a_cmd_valid = 1'b1; a_cmd_index = 3'd0; a_cmd_length = 4'd5;
    cyc;
    a_cmd_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      a_out_ready = rdy[c];
      @(negedge clk);
      n_total++; if (a_out_valid !== 1'b1) $display("FAIL bp_valid cycle %0d got %b want 1", c, a_out_valid); else n_pass++;
      n_total++; if (a_out_address !== 3'(ea[c])) $display("FAIL bp_addr cycle %0d got %0d want %0d", c, a_out_address, ea[c]); else n_pass++;
      n_total++; if (a_out_index !== 3'(ei[c])) $display("FAIL bp_index cycle %0d got %0d want %0d", c, a_out_index, ei[c]); else n_pass++;
      n_total++; if (a_out_last !== (c == 7)) $display("FAIL bp_last cycle %0d got %b want %b", c, a_out_last, c == 7); else n_pass++;
      cyc;
    end
    a_out_ready = 1'b1;
    @(negedge clk);
    n_total++; if (a_out_valid !== 1'b0) $display("FAIL bp_end valid got %b want 0", a_out_valid); else n_pass++;
    cyc;
  endtask

  task automatic test_rejects;
    int ri[3] = '{0, 0, 5};
    int rl[3] = '{0, 6, 1};
    for (int r = 0; r < 3; r++) begin
      a_cmd_valid = 1'b1; a_cmd_index = 3'(ri[r]); a_cmd_length = 4'(rl[r]);
      cyc;
      a_cmd_valid = 1'b0;
      @(negedge clk);
      n_total++; if (a_cmd_error !== 1'b1) $display("FAIL rej_error cmd %0d got %b want 1", r, a_cmd_error); else n_pass++;
      n_total++; if (a_out_valid !== 1'b0 || a_cmd_ready !== 1'b1) $display("FAIL rej_state cmd %0d valid=%b ready=%b want 0,1", r, a_out_valid, a_cmd_ready); else n_pass++;
      cyc;
      @(negedge clk);
      n_total++; if (a_cmd_error !== 1'b0) $display("FAIL rej_pulse cmd %0d got %b want 0", r, a_cmd_error); else n_pass++;
      n_total++; if (a_out_valid !== 1'b0) $display("FAIL rej_novalid cmd %0d got %b want 0", r, a_out_valid); else n_pass++;
    end
    cyc;
  endtask

  task automatic test_clear_abort;
    a_out_ready = 1'b1;
    a_cmd_valid = 1'b1; a_cmd_index = 3'd0; a_cmd_length = 4'd5;
    cyc;
    a_cmd_valid = 1'b0;
    @(negedge clk);
    n_total++; if (a_out_address !== 3'd6) $display("FAIL clr_beat0 got %0d want 6", a_out_address); else n_pass++;
    cyc;
    @(negedge clk);
    n_total++; if (a_out_address !== 3'd7) $display("FAIL clr_beat1 got %0d want 7", a_out_address); else n_pass++;
    cyc;
    a_clear = 1'b1;
    cyc;
    a_clear = 1'b0;
    a_cmd_valid = 1'b1; a_cmd_index = 3'd4; a_cmd_length = 4'd2;
    @(negedge clk);
    n_total++; if (a_out_valid !== 1'b0 || a_cmd_ready !== 1'b1) $display("FAIL clr_abort valid=%b ready=%b want 0,1", a_out_valid, a_cmd_ready); else n_pass++;
    cyc;
    a_cmd_valid = 1'b0;
    @(negedge clk);
    n_total++; if (a_out_address !== 3'd2 || a_out_index !== 3'd4) $display("FAIL clr_new0 addr=%0d idx=%0d want 2,4", a_out_address, a_out_index); else n_pass++;
    cyc;
    @(negedge clk);
    n_total++; if (a_out_address !== 3'd6 || a_out_index !== 3'd0 || a_out_last !== 1'b1) $display("FAIL clr_new1 addr=%0d idx=%0d last=%b want 6,0,1", a_out_address, a_out_index, a_out_last); else n_pass++;
    cyc;
    @(negedge clk);
    n_total++; if (a_out_valid !== 1'b0) $display("FAIL clr_end valid got %b want 0", a_out_valid); else n_pass++;
    cyc;
  endtask

  task automatic test_roundtrip_a;
    bit m_act = 1'b0;
    int m_idx = 0;
    int m_rem = 0;
    for (int c = 0; c < 2000; c++) begin
      a_cmd_valid  = ($urandom_range(0, 3) == 0);
      a_cmd_index  = 3'($urandom_range(0, 4));
      a_cmd_length = 4'($urandom_range(1, 5));
      a_out_ready  = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      n_total++; if (a_out_valid !== m_act) $display("FAIL rt_a_valid cycle %0d got %b want %b", c, a_out_valid, m_act); else n_pass++;
      if (m_act) begin
        n_total++; if (xlate_a(a_out_address) != int'(a_out_index)) $display("FAIL rt_a_xlate cycle %0d addr %0d maps to %0d want %0d", c, a_out_address, xlate_a(a_out_address), a_out_index); else n_pass++;
        n_total++; if (a_out_index !== 3'(m_idx)) $display("FAIL rt_a_index cycle %0d got %0d want %0d", c, a_out_index, m_idx); else n_pass++;
        n_total++; if (a_out_last !== (m_rem == 1)) $display("FAIL rt_a_last cycle %0d got %b want %b", c, a_out_last, m_rem == 1); else n_pass++;
        if (a_out_ready) begin
          m_idx = (m_idx == 4) ? 0 : m_idx + 1;
          m_rem--;
          if (m_rem == 0) m_act = 1'b0;
        end
      end else if (a_cmd_valid) begin
        m_act = 1'b1;
        m_idx = int'(a_cmd_index);
        m_rem = int'(a_cmd_length);
      end
      cyc;
    end
    a_cmd_valid = 1'b0; a_out_ready = 1'b1;
    for (int c = 0; c < 6; c++) cyc;
  endtask

  task automatic test_roundtrip_single;
    bit m_act = 1'b0;
    bit m_err = 1'b0;
    bit ok;
    for (int c = 0; c < 2000; c++) begin
      b_cmd_valid  = ($urandom_range(0, 2) == 0);
      b_cmd_index  = 1'($urandom_range(0, 3) == 0);
      b_cmd_length = 2'($urandom_range(0, 4) == 0 ? $urandom_range(0, 2) : 1);
      b_out_ready  = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      n_total++; if (b_out_valid !== m_act) $display("FAIL rt_b_valid cycle %0d got %b want %b", c, b_out_valid, m_act); else n_pass++;
      n_total++; if (b_cmd_error !== m_err) $display("FAIL rt_b_error cycle %0d got %b want %b", c, b_cmd_error, m_err); else n_pass++;
      m_err = 1'b0;
      if (m_act) begin
        n_total++; if (b_out_address !== 1'b1) $display("FAIL rt_b_addr cycle %0d got %0d want 1", c, b_out_address); else n_pass++;
        n_total++; if (xlate_b(b_out_address) != 0 || b_out_index !== 1'b0) $display("FAIL rt_b_xlate cycle %0d idx %0d maps %0d want 0", c, b_out_index, xlate_b(b_out_address)); else n_pass++;
        n_total++; if (b_out_last !== 1'b1) $display("FAIL rt_b_last cycle %0d got %b want 1", c, b_out_last); else n_pass++;
        if (b_out_ready) m_act = 1'b0;
      end else if (b_cmd_valid) begin
        ok = (b_cmd_length == 2'd1) && (b_cmd_index == 1'b0);
        m_act = ok;
        m_err = !ok;
      end
      cyc;
    end
    b_cmd_valid = 1'b0;
  endtask

  initial begin
    test_reset;
    test_full_burst;
    test_wrap_burst;
    test_backpressure;
    test_rejects;
    test_clear_abort;
    test_roundtrip_a;
    test_roundtrip_single;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
